// File: rtl/audio_clk_pkg.sv
// Shared types and defaults for the audio clock qualification and timebase stage.
package audio_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } clk_state_e;

    // Defaults for a 48 kHz sample rate on a 100 MHz fabric clock
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_SAMPLE_DIV         = 2083;
    localparam int unsigned DEF_BIT_DIV            = 32;
    localparam int unsigned DEF_LOCK_TIMEOUT       = 65535;
    localparam int unsigned DEF_CNT_W              = 16;
    localparam int unsigned FRAME_W                = 8;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/audio_tick_div.sv
// Terminal-count divider: one registered tick every DIV enabled cycles, synchronous clear.
module audio_tick_div #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_W'(DIV - 1)) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/audio_clk_seq.sv
// Holds audio logic in reset until CCC lock is stable, then generates sample/bit strobes.
// Optional lock watchdog / CCC-bypass degraded mode: AUDIO_CLK_SEQ_LOCK_TIMEOUT_EN.
module audio_clk_seq
    import audio_clk_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned SAMPLE_DIV         = DEF_SAMPLE_DIV,
    parameter int unsigned BIT_DIV            = DEF_BIT_DIV,
    parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int unsigned CNT_W              = DEF_CNT_W
) (
    input  logic               FAB_CLK,
    input  logic               M2F_RESET_N,
    input  logic               FAB_LOCK,
    input  logic               enable,
    input  logic               clr_fault,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               sample_tick,
    output logic               bit_tick,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               lock_lost,
    output logic               lock_timeout
);

    localparam int unsigned MAX_CNT =
        max2(max2(LOCK_STABLE_CYCLES, LOCK_TIMEOUT), max2(SAMPLE_DIV, BIT_DIV));

    if (CNT_W < $clog2(MAX_CNT + 1)) begin : g_cnt_w_too_narrow
        $error("audio_clk_seq: CNT_W cannot hold the largest count parameter");
    end

    clk_state_e         state_q, state_d;
    logic               lock_meta_q, lock_s_q;
    logic [CNT_W-1:0]   stab_q, stab_d;
    logic               sys_rst_n_q, sys_rst_n_d;
    logic               ready_q, ready_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               lost_q, lost_d;
    logic               timeout_q, timeout_d;
    logic               fault_c, run_stay_c, div_clr_c;

`ifdef AUDIO_CLK_SEQ_LOCK_TIMEOUT_EN
    logic [CNT_W-1:0]   wd_q, wd_d;
`endif

    // Next-state, stability counter and watchdog
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        fault_c   = 1'b0;
        timeout_d = timeout_q;
`ifdef AUDIO_CLK_SEQ_LOCK_TIMEOUT_EN
        wd_d      = '0;
`endif
        case (state_q)
            WAIT_LOCK: begin
                stab_d = '0;
                if (lock_s_q) begin
                    state_d = STABLE;
`ifdef AUDIO_CLK_SEQ_LOCK_TIMEOUT_EN
                end else if (wd_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d   = RUN;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + CNT_W'(1);
`endif
                end
            end
            STABLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    stab_d  = '0;
                end else if (stab_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Degraded mode (lock_timeout set) ignores lock entirely
                if (!lock_s_q && !timeout_q) begin
                    state_d = FAULT;
                    fault_c = 1'b1;
                end
            end
            FAULT:   state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Registered outputs drop together with the transition into FAULT
    always_comb begin
        run_stay_c  = (state_q == RUN) && (state_d == RUN);
        div_clr_c   = !(run_stay_c && enable);
        sys_rst_n_d = run_stay_c;
        ready_d     = run_stay_c;

        frame_d = frame_q;
        if (fault_c || (state_q == FAULT)) begin
            frame_d = '0;
        end else if (sample_tick) begin
            frame_d = frame_q + FRAME_W'(1);
        end

        lost_d = lost_q;
        if (fault_c) begin
            lost_d = 1'b1;
        end else if (clr_fault) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            stab_q      <= '0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            frame_q     <= '0;
            lost_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            lock_meta_q <= FAB_LOCK;
            lock_s_q    <= lock_meta_q;
            state_q     <= state_d;
            stab_q      <= stab_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            frame_q     <= frame_d;
            lost_q      <= lost_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef AUDIO_CLK_SEQ_LOCK_TIMEOUT_EN
    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`endif

    audio_tick_div #(.DIV(SAMPLE_DIV), .CNT_W(CNT_W)) u_sample_div (
        .clk   (FAB_CLK),
        .rst_n (M2F_RESET_N),
        .clr   (div_clr_c),
        .en    (enable),
        .tick  (sample_tick)
    );

    audio_tick_div #(.DIV(BIT_DIV), .CNT_W(CNT_W)) u_bit_div (
        .clk   (FAB_CLK),
        .rst_n (M2F_RESET_N),
        .clr   (div_clr_c),
        .en    (enable),
        .tick  (bit_tick)
    );

    assign sys_rst_n    = sys_rst_n_q;
    assign ready        = ready_q;
    assign frame_cnt    = frame_q;
    assign lock_lost    = lost_q;
    assign lock_timeout = timeout_q;

endmodule
